// File: rtl/i2c_wb_sequencer.sv
// Wishbone master that sequences complete I2C transactions through the iicmb_m_wb
// register file (CSR/DPR/CMDR/FSMR) behind a request / byte-stream client interface.
module i2c_wb_sequencer #(
    parameter int unsigned WB_ADDR_WIDTH  = 2,
    parameter int unsigned WB_DATA_WIDTH  = 8,
    parameter int unsigned NUM_I2C_BUSSES = 1,
    parameter int unsigned I2C_ADDR_WIDTH = 7,
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    localparam int unsigned BW = (NUM_I2C_BUSSES > 1) ? $clog2(NUM_I2C_BUSSES) : 1,
    localparam int unsigned LW = $clog2(MAX_LEN + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [BW-1:0]             req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic                      req_rw_i,
    input  logic [LW-1:0]             req_len_i,
    input  logic                      wdata_valid_i,
    output logic                      wdata_ready_o,
    input  logic [7:0]                wdata_i,
    output logic                      rdata_valid_o,
    output logic [7:0]                rdata_o,
    output logic                      done_o,
    output logic [1:0]                status_o,
    output logic                      busy_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      ack_i,
    input  logic                      irq_i
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [WB_ADDR_WIDTH-1:0] AdrCsr  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] AdrDpr  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] AdrCmdr = WB_ADDR_WIDTH'(2);

    localparam logic [7:0] CsrEnable = 8'hC0;
    localparam logic [7:0] CmdWrite  = 8'h01;
    localparam logic [7:0] CmdRdAck  = 8'h02;
    localparam logic [7:0] CmdRdNak  = 8'h03;
    localparam logic [7:0] CmdStart  = 8'h04;
    localparam logic [7:0] CmdStop   = 8'h05;
    localparam logic [7:0] CmdSetBus = 8'h06;

    typedef enum logic [3:0] {
        StInitCsr, StIdle, StBusDpr, StBusCmd, StStartCmd, StAddrDpr, StAddrCmd, StWrData,
        StWrDpr, StWrCmd, StRdCmd, StRdDpr, StStopCmd, StWaitIrq, StRdCmdr, StDone
    } state_e;

    state_e                      state_q, state_d;
    state_e                      ret_q, ret_d;
    logic [LW-1:0]               cnt_q, cnt_d;
    logic [1:0]                  txst_q, txst_d;
    logic                        bvalid_q, bvalid_d;
    logic [BW-1:0]               bcache_q, bcache_d;
    logic [TW-1:0]               tmo_q, tmo_d;

    logic [BW-1:0]               bus_q;
    logic [I2C_ADDR_WIDTH-1:0]   addr_q;
    logic                        rw_q;
    logic [7:0]                  wbyte_q;
    logic [7:0]                  rdata_q;
    logic                        rdata_valid_q;
    logic [1:0]                  status_q;
    logic                        wb_busy_q;

    logic                        wb_req, wb_we, wb_done;
    logic [WB_ADDR_WIDTH-1:0]    wb_adr;
    logic [WB_DATA_WIDTH-1:0]    wb_dat;

    assign wb_done = wb_busy_q & ack_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= StInitCsr;
            ret_q    <= StIdle;
            cnt_q    <= '0;
            txst_q   <= '0;
            bvalid_q <= 1'b0;
            bcache_q <= '0;
            tmo_q    <= '0;
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            cnt_q    <= cnt_d;
            txst_q   <= txst_d;
            bvalid_q <= bvalid_d;
            bcache_q <= bcache_d;
            tmo_q    <= tmo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ret_d    = ret_q;
        cnt_d    = cnt_q;
        txst_d   = txst_q;
        bvalid_d = bvalid_q;
        bcache_d = bcache_q;
        tmo_d    = '0;
        unique case (state_q)
            StInitCsr: if (wb_done) state_d = StIdle;
            StIdle: begin
                if (req_valid_i) begin
                    txst_d = 2'b00;
                    cnt_d  = req_len_i;
                    if (req_len_i > LW'(MAX_LEN)) begin
                        txst_d  = 2'b11;
                        state_d = StDone;
                    end else if (bvalid_q && (bcache_q == req_bus_i)) begin
                        state_d = StStartCmd;
                    end else begin
                        state_d = StBusDpr;
                    end
                end
            end
            StBusDpr:  if (wb_done) state_d = StBusCmd;
            StBusCmd:  if (wb_done) begin state_d = StWaitIrq; ret_d = StStartCmd; end
            StStartCmd: if (wb_done) begin state_d = StWaitIrq; ret_d = StAddrDpr; end
            StAddrDpr: if (wb_done) state_d = StAddrCmd;
            StAddrCmd: begin
                if (wb_done) begin
                    state_d = StWaitIrq;
                    ret_d   = (cnt_q == '0) ? StStopCmd : (rw_q ? StRdCmd : StWrData);
                end
            end
            StWrData: begin
                if (wdata_valid_i) begin
                    state_d = StWrDpr;
                    if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
                end
            end
            StWrDpr: if (wb_done) state_d = StWrCmd;
            StWrCmd: begin
                if (wb_done) begin
                    state_d = StWaitIrq;
                    ret_d   = (cnt_q == '0) ? StStopCmd : StWrData;
                end
            end
            StRdCmd: if (wb_done) begin state_d = StWaitIrq; ret_d = StRdDpr; end
            StRdDpr: begin
                if (wb_done) begin
                    if (cnt_q != '0) cnt_d = cnt_q - LW'(1);
                    state_d = (cnt_q <= LW'(1)) ? StStopCmd : StRdCmd;
                end
            end
            StStopCmd: if (wb_done) begin state_d = StWaitIrq; ret_d = StDone; end
            StWaitIrq: begin
                if (irq_i) begin
                    state_d = StRdCmdr;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    txst_d   = 2'b11;
                    bvalid_d = 1'b0;
                    state_d  = StDone;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            StRdCmdr: begin
                if (wb_done) begin
                    if (dat_i[7]) begin
                        state_d = ret_q;
                        // Only a completed set-bus command returns to StStartCmd.
                        if (ret_q == StStartCmd) begin
                            bvalid_d = 1'b1;
                            bcache_d = bus_q;
                        end
                    end else if (dat_i[6]) begin
                        txst_d  = 2'b01;
                        state_d = (ret_q == StDone) ? StDone : StStopCmd;
                    end else begin
                        txst_d   = dat_i[5] ? 2'b10 : 2'b11;
                        bvalid_d = 1'b0;
                        state_d  = StDone;
                    end
                end
            end
            StDone: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            bus_q         <= '0;
            addr_q        <= '0;
            rw_q          <= 1'b0;
            wbyte_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            status_q      <= '0;
            wb_busy_q     <= 1'b0;
        end else begin
            if (state_q == StIdle && req_valid_i) begin
                bus_q  <= req_bus_i;
                addr_q <= req_addr_i;
                rw_q   <= req_rw_i;
            end
            if (state_q == StWrData && wdata_valid_i) wbyte_q <= wdata_i;
            rdata_valid_q <= (state_q == StRdDpr) && wb_done;
            if (state_q == StRdDpr && wb_done) rdata_q <= dat_i[7:0];
            if (state_d == StDone) status_q <= txst_d;
            // Dropping busy on ack guarantees an idle cycle before the next access.
            if (wb_busy_q) begin
                if (ack_i) wb_busy_q <= 1'b0;
            end else if (wb_req) begin
                wb_busy_q <= 1'b1;
            end
        end
    end

    always_comb begin
        wb_req = 1'b1;
        wb_we  = 1'b1;
        wb_adr = AdrCmdr;
        wb_dat = '0;
        unique case (state_q)
            StInitCsr:  begin wb_adr = AdrCsr; wb_dat = WB_DATA_WIDTH'(CsrEnable); end
            StBusDpr:   begin wb_adr = AdrDpr; wb_dat = WB_DATA_WIDTH'(bus_q); end
            StBusCmd:   wb_dat = WB_DATA_WIDTH'(CmdSetBus);
            StStartCmd: wb_dat = WB_DATA_WIDTH'(CmdStart);
            StAddrDpr:  begin wb_adr = AdrDpr; wb_dat = WB_DATA_WIDTH'({addr_q, rw_q}); end
            StAddrCmd:  wb_dat = WB_DATA_WIDTH'(CmdWrite);
            StWrDpr:    begin wb_adr = AdrDpr; wb_dat = WB_DATA_WIDTH'(wbyte_q); end
            StWrCmd:    wb_dat = WB_DATA_WIDTH'(CmdWrite);
            StRdCmd:    wb_dat = WB_DATA_WIDTH'((cnt_q == LW'(1)) ? CmdRdNak : CmdRdAck);
            StRdDpr:    begin wb_we = 1'b0; wb_adr = AdrDpr; end
            StStopCmd:  wb_dat = WB_DATA_WIDTH'(CmdStop);
            StRdCmdr:   wb_we = 1'b0;
            StIdle, StWrData, StWaitIrq, StDone: wb_req = 1'b0;
        endcase
    end

    assign cyc_o         = wb_busy_q;
    assign stb_o         = wb_busy_q;
    assign we_o          = wb_busy_q & wb_we;
    assign adr_o         = wb_busy_q ? wb_adr : '0;
    assign dat_o         = (wb_busy_q && wb_we) ? wb_dat : '0;
    assign req_ready_o   = (state_q == StIdle);
    assign wdata_ready_o = (state_q == StWrData);
    assign done_o        = (state_q == StDone);
    assign busy_o        = (state_q != StIdle) && (state_q != StInitCsr);
    assign rdata_valid_o = rdata_valid_q;
    assign rdata_o       = rdata_q;
    assign status_o      = status_q;

endmodule

// File: tb/tb_i2c_wb_sequencer.sv
// Scoreboard bench for i2c_wb_sequencer: a transaction-level model predicts the register
// traffic, read bytes and completion status; a controller model answers on Wishbone/irq.
module tb_i2c_wb_sequencer;

    localparam int unsigned NB  = 2;
    localparam int unsigned ML  = 16;
    localparam int unsigned TMO = 100;
    localparam int unsigned LW  = $clog2(ML + 1);

    typedef struct packed {logic we; logic [1:0] adr; logic [7:0] dat;} wb_t;
    typedef struct packed {logic [1:0] st; logic tmo; logic [31:0] beats;} done_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [0:0] req_bus = '0;
    logic [6:0] req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic       wdata_valid = 1'b0, wdata_ready;
    logic [7:0] wdata = '0, rdata;
    logic       rdata_valid, done, busy, cyc, stb, we;
    logic [1:0] status, adr;
    logic [7:0] dat_o, dat_r;
    logic       ack_r, irq_r;

    i2c_wb_sequencer #(
        .WB_ADDR_WIDTH(2), .WB_DATA_WIDTH(8), .NUM_I2C_BUSSES(NB), .I2C_ADDR_WIDTH(7),
        .MAX_LEN(ML), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_bus_i(req_bus),
        .req_addr_i(req_addr), .req_rw_i(req_rw), .req_len_i(req_len),
        .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
        .rdata_valid_o(rdata_valid), .rdata_o(rdata), .done_o(done), .status_o(status),
        .busy_o(busy), .cyc_o(cyc), .stb_o(stb), .we_o(we), .adr_o(adr), .dat_o(dat_o),
        .dat_i(dat_r), .ack_i(ack_r), .irq_i(irq_r)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, done_cnt = 0, beat_cnt = 0, cyc_cnt = 0, last_cmdr_cyc = 0;
    wb_t        exp_wb[$];
    logic [7:0] exp_rd[$];
    done_t      exp_done[$];
    logic [7:0] slv_resp[$];  // 8'h00 means never raise irq
    logic [7:0] slv_dpr[$];
    logic [7:0] wq[$];
    logic [7:0] fixed_q[$];
    bit         m_cache_valid = 1'b0;
    logic       m_cache_bus = 1'b0;
    int         fault_at = -1, fault_kind = 0, cmd_idx = 0;
    bit         stuck = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc_cnt);
        end
    endtask

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Controller model: random ack latency, irq some cycles after each CMDR write.
    int         ack_wait, irq_wait;
    logic       irq_pend;
    logic [7:0] cur_resp, pend_resp;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0; dat_r <= '0; irq_r <= 1'b0; ack_wait <= 0; irq_wait <= 0;
            irq_pend <= 1'b0; cur_resp <= '0; pend_resp <= '0;
        end else begin
            if (irq_pend) begin
                if (irq_wait == 0) begin
                    irq_r <= 1'b1; cur_resp <= pend_resp; irq_pend <= 1'b0;
                end else irq_wait <= irq_wait - 1;
            end
            if (ack_r) ack_r <= 1'b0;
            else if (cyc && stb) begin
                if (ack_wait > 0) ack_wait <= ack_wait - 1;
                else begin
                    ack_r <= 1'b1;
                    ack_wait <= $urandom_range(0, 2);
                    if (we && adr == 2'd2 && slv_resp.size() > 0) begin
                        if (slv_resp[0] != 8'h00) begin
                            irq_pend <= 1'b1; irq_wait <= $urandom_range(0, 4);
                            pend_resp <= slv_resp[0];
                        end
                        void'(slv_resp.pop_front());
                    end else if (!we && adr == 2'd2) begin
                        dat_r <= cur_resp; irq_r <= 1'b0;
                    end else if (!we && adr == 2'd1) begin
                        if (slv_dpr.size() > 0) dat_r <= slv_dpr.pop_front();
                        else dat_r <= 8'hEE;
                    end
                end
            end
        end
    end

    // Write-byte source: presents the queue head, pops on each accepted beat.
    always @(negedge clk) begin
        if (!rst_n) wdata_valid = 1'b0;
        else begin
            wdata_valid = (wq.size() > 0);
            if (wdata_valid) wdata = wq[0];
            if (wdata_valid && wdata_ready) begin
                void'(wq.pop_front());
                beat_cnt++;
            end
        end
    end

    // Monitor / scoreboard.
    wb_t   mon_e;
    done_t mon_d;
    always @(negedge clk) begin
        if (rst_n) begin
            if (cyc && stb && ack_r) begin
                if (exp_wb.size() == 0) check("wb_unexpected", {we, adr, dat_o}, 32'hFFFF);
                else begin
                    mon_e = exp_wb.pop_front();
                    check("wb_cycle", {we, adr, (mon_e.we ? dat_o : 8'h00)},
                          {mon_e.we, mon_e.adr, mon_e.dat});
                end
                if (we && adr == 2'd2) last_cmdr_cyc = cyc_cnt;
            end
            if (rdata_valid) begin
                if (exp_rd.size() == 0) check("rdata_unexpected", rdata, 32'hFFFF);
                else check("rdata", rdata, exp_rd.pop_front());
            end
            if (done) begin
                if (exp_done.size() == 0) check("done_unexpected", status, 32'hFFFF);
                else begin
                    mon_d = exp_done.pop_front();
                    check("status", status, mon_d.st);
                    check("wdata_beats", beat_cnt, mon_d.beats);
                    check("busy_at_done", busy, 1);
                    if (mon_d.tmo) check("timeout_latency", cyc_cnt, last_cmdr_cyc + TMO + 1);
                end
                done_cnt++;
            end
        end
    end

    task automatic exp_w(input logic [1:0] a, input logic [7:0] d);
        exp_wb.push_back('{1'b1, a, d});
    endtask

    task automatic exp_r(input logic [1:0] a);
        exp_wb.push_back('{1'b0, a, 8'h00});
    endtask

    function automatic logic [7:0] next_byte();
        if (fixed_q.size() > 0) return fixed_q.pop_front();
        return 8'($urandom);
    endfunction

    // One controller command: register write, controller answer, CMDR read-back.
    task automatic model_cmd(input logic [7:0] code, output int r);
        exp_w(2'd2, code);
        r = (cmd_idx == fault_at) ? fault_kind : 0;
        cmd_idx++;
        case (r)
            0: slv_resp.push_back(8'h80);
            1: slv_resp.push_back(8'h40);
            2: slv_resp.push_back(8'h20);
            3: slv_resp.push_back(8'h10);
            default: slv_resp.push_back(8'h00);
        endcase
        if (r != 4) exp_r(2'd2);
    endtask

    // Transaction-level model: kinds 1 NAK, 2 arbitration lost, 3 error, 4 no irq.
    task automatic model_txn(input logic bus, input logic [6:0] addr, input logic rw,
                             input int len, input int f_at, input int f_kind);
        int r = 0, r2;
        logic [7:0] b;
        int beats = 0;
        logic [1:0] st;
        cmd_idx = 0; fault_at = f_at; fault_kind = f_kind;
        if (len > ML) begin
            exp_done.push_back('{2'b11, 1'b0, 32'd0});
            return;
        end
        if (!(m_cache_valid && m_cache_bus == bus)) begin
            exp_w(2'd1, {7'b0, bus});
            model_cmd(8'h06, r);
            if (r == 0) begin m_cache_valid = 1'b1; m_cache_bus = bus; end
        end
        if (r == 0) model_cmd(8'h04, r);
        if (r == 0) begin exp_w(2'd1, {addr, rw}); model_cmd(8'h01, r); end
        for (int i = 0; i < len && r == 0; i++) begin
            b = next_byte();
            if (!rw) begin
                wq.push_back(b); beats++;
                exp_w(2'd1, b);
                model_cmd(8'h01, r);
            end else begin
                model_cmd((i == len - 1) ? 8'h03 : 8'h02, r);
                if (r == 0) begin slv_dpr.push_back(b); exp_r(2'd1); exp_rd.push_back(b); end
            end
        end
        st = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : (r == 2) ? 2'b10 : 2'b11;
        if (r <= 1) begin fault_at = -1; model_cmd(8'h05, r2); end
        else m_cache_valid = 1'b0;
        exp_done.push_back('{st, (r == 4), 32'(beats)});
    endtask

    task automatic issue(input logic bus, input logic [6:0] addr, input logic rw, input int len);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 300) begin @(negedge clk); k++; end
        check("req_ready_wait", req_ready, 1);
        req_bus = bus; req_addr = addr; req_rw = rw; req_len = LW'(len); req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic do_txn(input logic bus, input logic [6:0] addr, input logic rw,
                          input int len, input int f_at, input int f_kind);
        int n0 = done_cnt, k = 0;
        if (stuck) return;
        beat_cnt = 0;
        model_txn(bus, addr, rw, len, f_at, f_kind);
        issue(bus, addr, rw, len);
        while (done_cnt == n0 && k < 5000) begin @(negedge clk); k++; end
        if (done_cnt == n0) begin
            check("done_wait", 0, 1);
            stuck = 1'b1;
        end
    endtask

    task automatic wait_ready_after_reset();
        int k = 0;
        while (!req_ready && k < 100) begin @(negedge clk); k++; end
        check("ready_after_reset", req_ready, 1);
        check("csr_before_ready", exp_wb.size(), 0);
    endtask

    initial begin
        #900000;
        errors++;
        $display("FAIL watchdog expired at cycle %0d", cyc_cnt);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        logic rb, rrw;
        logic [6:0] ra;
        int rl, rf, rk;
        repeat (3) @(negedge clk);
        check("reset_outputs", {cyc, stb, we, adr, dat_o, req_ready, wdata_ready, rdata_valid,
                                rdata, done, status, busy}, 0);
        exp_w(2'd0, 8'hC0);
        rst_n = 1'b1;
        wait_ready_after_reset();

        fixed_q = '{8'h44, 8'h78};
        do_txn(1'b0, 7'h22, 1'b0, 2, -1, 0);
        fixed_q = '{8'hA1, 8'hB2, 8'hC3};
        do_txn(1'b0, 7'h22, 1'b1, 3, -1, 0);
        do_txn(1'b0, 7'h22, 1'b0, 1, -1, 0);
        do_txn(1'b1, 7'h51, 1'b1, 1, -1, 0);
        do_txn(1'b1, 7'h22, 1'b0, 3, 1, 1);   // address NAK
        do_txn(1'b1, 7'h22, 1'b0, 1, 0, 4);   // irq never arrives on START
        do_txn(1'b0, 7'h10, 1'b0, 17, -1, 0); // over-length request
        do_txn(1'b0, 7'h10, 1'b1, 0, -1, 0);  // address-only probe

        // Reset while a Wishbone cycle is in flight.
        if (!stuck) begin
            model_txn(1'b1, 7'h33, 1'b0, 2, -1, 0);
            issue(1'b1, 7'h33, 1'b0, 2);
            k = 0;
            while (!stb && k < 50) begin @(negedge clk); k++; end
            check("stb_before_reset", stb, 1);
            rst_n = 1'b0;
            #1;
            check("reset_outputs_mid", {cyc, stb, we, adr, dat_o, req_ready, wdata_ready,
                                        rdata_valid, rdata, done, status, busy}, 0);
            exp_wb.delete(); exp_rd.delete(); exp_done.delete();
            slv_resp.delete(); slv_dpr.delete(); wq.delete(); fixed_q.delete();
            m_cache_valid = 1'b0;
            exp_w(2'd0, 8'hC0);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            wait_ready_after_reset();
            do_txn(1'b1, 7'h33, 1'b0, 2, -1, 0);
        end

        for (int t = 0; t < 40; t++) begin
            rb = 1'($urandom_range(0, 1));
            ra = 7'($urandom);
            rrw = 1'($urandom_range(0, 1));
            rl = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 20))
                                             : int'($urandom_range(0, 6));
            if ($urandom_range(0, 3) == 0) begin
                rf = int'($urandom_range(0, rl + 2));
                rk = int'($urandom_range(1, 4));
            end else begin
                rf = -1; rk = 0;
            end
            do_txn(rb, ra, rrw, rl, rf, rk);
        end

        repeat (5) @(negedge clk);
        check("drain_wb", exp_wb.size(), 0);
        check("drain_rdata", exp_rd.size(), 0);
        check("drain_done", exp_done.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
